// File: rtl/div_unit_if.sv
// Execute-stage divide port bundle: pipeline (master) drives the operands and
// control, divider (slave) returns stall, ready and the {HI, LO} result.
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic               startE;
   logic               signedE;
   logic               annulE;
   logic [WIDTH-1:0]   srcaE;
   logic [WIDTH-1:0]   srcbE;
   logic               stall_divE;
   logic               readyE;
   logic [2*WIDTH-1:0] resultE;

   modport master (
      output startE, signedE, annulE, srcaE, srcbE,
      input  stall_divE, readyE, resultE
   );

   modport slave (
      input  startE, signedE, annulE, srcaE, srcbE,
      output stall_divE, readyE, resultE
   );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle; result {rem, quo}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the CALC iterations.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_rem, r_quo, r_dvs, r_dvd_raw;
   logic               r_qsign, r_rsign, r_dz;
   logic [2*WIDTH-1:0] r_result;

   logic               w_start, w_a_neg, w_b_neg, w_b_zero, w_ge, w_last;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_rem_nxt, w_quo_nxt, w_q_fix, w_r_fix;
   logic [WIDTH:0]     w_shift, w_diff;
   logic [2*WIDTH-1:0] w_result;

   always_comb begin
      w_start   = bus.startE & ~bus.annulE;
      w_a_neg   = bus.signedE & bus.srcaE[WIDTH-1];
      w_b_neg   = bus.signedE & bus.srcbE[WIDTH-1];
      w_abs_a   = w_a_neg ? -bus.srcaE : bus.srcaE;
      w_abs_b   = w_b_neg ? -bus.srcbE : bus.srcbE;
      w_b_zero  = (bus.srcbE == '0);
      // Partial remainder is always below the divisor, so the low WIDTH bits of
      // the difference hold the whole new remainder.
      w_shift   = {r_rem, r_quo[WIDTH-1]};
      w_diff    = w_shift - {1'b0, r_dvs};
      w_ge      = ~w_diff[WIDTH];
      w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
      w_last    = (r_cnt == CNT_W'(WIDTH-1));
      w_q_fix   = r_qsign ? -w_quo_nxt : w_quo_nxt;
      w_r_fix   = r_rsign ? -w_rem_nxt : w_rem_nxt;
      w_result  = r_dz ? {r_dvd_raw, {WIDTH{1'b1}}} : {w_r_fix, w_q_fix};
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_start) begin
`ifdef DIV_ZERO_FAST_EN
               w_state_nxt = w_b_zero ? DONE : CALC;
`else
               w_state_nxt = CALC;
`endif
            end
         end
         CALC:    if (w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (bus.annulE) w_state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_dvs     <= '0;
         r_dvd_raw <= '0;
         r_qsign   <= 1'b0;
         r_rsign   <= 1'b0;
         r_dz      <= 1'b0;
         r_result  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_start) begin
                  r_cnt     <= '0;
                  r_rem     <= '0;
                  r_quo     <= w_abs_a;
                  r_dvs     <= w_abs_b;
                  r_dvd_raw <= bus.srcaE;
                  r_qsign   <= w_a_neg ^ w_b_neg;
                  r_rsign   <= w_a_neg;
                  r_dz      <= w_b_zero;
`ifdef DIV_ZERO_FAST_EN
                  if (w_b_zero) r_result <= {bus.srcaE, {WIDTH{1'b1}}};
`endif
               end
            end
            CALC: begin
               if (!bus.annulE) begin
                  r_rem <= w_rem_nxt;
                  r_quo <= w_quo_nxt;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (w_last) r_result <= w_result;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.stall_divE = w_start & (r_state != DONE);
   assign bus.readyE     = (r_state == DONE) & ~bus.annulE;
   assign bus.resultE    = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, stall window, signed fixup,
// divide-by-zero, annul and mid-operation reset.
module tb_div_unit;
   localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 33;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_pass = 0;

   div_unit_if #(.WIDTH(W)) bus ();

   div_unit #(.WIDTH(W), .CNT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Holds startE until readyE; checks latency, stall window and result.
   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, input logic [63:0] exp, input int lat);
      int  n;
      logic stall_ok;
      bus.srcaE   = a;
      bus.srcbE   = b;
      bus.signedE = sgn;
      bus.startE  = 1'b1;
      #1;
      n = 0;
      stall_ok = 1'b1;
      while (!bus.readyE && n < 100) begin
         if (!bus.stall_divE) stall_ok = 1'b0;
         step();
         n++;
      end
      chk({tag, "_lat"},    64'(n), 64'(lat));
      chk({tag, "_stall"},  64'(stall_ok), 64'd1);
      chk({tag, "_nostall_done"}, 64'(bus.stall_divE), 64'd0);
      chk({tag, "_res"},    bus.resultE, exp);
      step();
      bus.startE = 1'b0;
      #1;
      chk({tag, "_ready_pulse"}, 64'(bus.readyE), 64'd0);
   endtask

   initial begin
      rst         = 1'b1;
      bus.startE  = 1'b0;
      bus.signedE = 1'b0;
      bus.annulE  = 1'b0;
      bus.srcaE   = '0;
      bus.srcbE   = '0;
      step();
      step();
      chk("rst_result", bus.resultE, 64'd0);
      chk("rst_ready",  64'(bus.readyE), 64'd0);
      chk("rst_stall",  64'(bus.stall_divE), 64'd0);
      rst = 1'b0;
      step();

      run_div("divu_ffff_2", 32'hFFFF_FFFF, 32'd2, 1'b0, {32'h1, 32'h7FFF_FFFF}, 33);
      run_div("div_m7_2",    32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
      run_div("div_7_m2",    32'd7, 32'hFFFF_FFFE, 1'b1, {32'h1, 32'hFFFF_FFFD}, 33);
      run_div("div_min_m1",  32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000}, 33);
      run_div("div_m5_0",    32'hFFFF_FFFB, 32'd0, 1'b1, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, ZLAT);
      run_div("divu_5_0",    32'd5, 32'd0, 1'b0, {32'h5, 32'hFFFF_FFFF}, ZLAT);

      // Annul in cycle 10 of DIVU 100/7
      bus.srcaE   = 32'd100;
      bus.srcbE   = 32'd7;
      bus.signedE = 1'b0;
      bus.startE  = 1'b1;
      for (int i = 0; i < 10; i++) step();
      bus.annulE = 1'b1;
      #1;
      chk("annul_stall", 64'(bus.stall_divE), 64'd0);
      chk("annul_ready", 64'(bus.readyE), 64'd0);
      step();
      bus.annulE = 1'b0;
      bus.startE = 1'b0;
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if (bus.readyE) seen = 1'b1;
            step();
         end
         chk("annul_no_ready", 64'(seen), 64'd0);
      end
      chk("annul_res_kept", bus.resultE, {32'h5, 32'hFFFF_FFFF});
      run_div("divu_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33);

      // Reset in cycle 20 of a divide
      bus.srcaE  = 32'd1000;
      bus.srcbE  = 32'd3;
      bus.startE = 1'b1;
      for (int i = 0; i < 20; i++) step();
      rst        = 1'b1;
      bus.startE = 1'b0;
      step();
      chk("mid_rst_result", bus.resultE, 64'd0);
      chk("mid_rst_ready",  64'(bus.readyE), 64'd0);
      rst = 1'b0;
      begin
         logic seen = 1'b0;
         for (int i = 0; i < 40; i++) begin
            if (bus.readyE) seen = 1'b1;
            step();
         end
         chk("mid_rst_no_ready", 64'(seen), 64'd0);
      end
      chk("mid_rst_res_zero", bus.resultE, 64'd0);

      // Back-to-back: second start in the cycle right after DONE
      run_div("divu_9_3",  32'd9,  32'd3, 1'b0, {32'd0, 32'd3}, 33);
      run_div("divu_10_4", 32'd10, 32'd4, 1'b0, {32'd2, 32'd2}, 33);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
